dfr_reservoir_sequencer: RTL and testbench



---
 rtl/dfr_reservoir_sequencer.sv | 152 +++++++++++++++
 tb/tb_dfr_reservoir_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfr_reservoir_sequencer.sv
// Delayed-feedback reservoir sequencer: walks the virtual nodes for each
// input sample and drives one ASIC conversion per node.
module dfr_reservoir_sequencer #(
    parameter int NUM_NODES      = 16,
    parameter int NODE_W         = $clog2(NUM_NODES),
    parameter int INPUT_SHIFT    = 1,
    parameter int FEEDBACK_SHIFT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [15:0]       sample_data,
    output logic              sample_ready,
    input  logic              mask_wr_en,
    input  logic [NODE_W-1:0] mask_wr_addr,
    input  logic [15:0]       mask_wr_data,
    input  logic              clear,
    output logic              asic_start,
    output logic [15:0]       asic_data_in,
    input  logic              asic_ready,
    input  logic [15:0]       asic_data_out,
    output logic              node_valid,
    output logic [NODE_W-1:0] node_idx,
    output logic [15:0]       node_data,
    output logic              sample_done,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_COMPUTE,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_WRITE
    } state_t;

    localparam logic [NODE_W-1:0] LAST = NODE_W'(NUM_NODES - 1);

    logic [15:0] mask_mem [NUM_NODES];
    logic [15:0] res_mem  [NUM_NODES];

    state_t            state;
    logic [NODE_W-1:0] idx;
    logic [15:0]       sample_q;
    logic [15:0]       mask_q;
    logic [15:0]       res_q;
    logic [15:0]       t_in;
    logic [15:0]       t_fb;
    logic [16:0]       sum;
    logic [15:0]       word;

    assign sample_ready = (state == S_IDLE) && !clear;

    // Upper half of the Q0.16 product is the masked input term.
    assign t_in = 16'((32'(sample_q) * 32'(mask_q)) >> (16 + INPUT_SHIFT));
    assign t_fb = res_q >> FEEDBACK_SHIFT;
    assign sum  = {1'b0, t_in} + {1'b0, t_fb};
    assign word = sum[16] ? 16'hFFFF : sum[15:0];

    // Memories are deliberately not reset; software uses clear.
    always_ff @(posedge clk) begin
        if (!rst && state == S_IDLE && mask_wr_en)
            mask_mem[mask_wr_addr] <= mask_wr_data;
        if (!rst && state == S_CLEAR)
            res_mem[idx] <= '0;
        else if (!rst && state == S_WRITE)
            res_mem[idx] <= asic_data_out;
        if (state == S_FETCH) begin
            mask_q <= mask_mem[idx];
            res_q  <= res_mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            sample_q     <= '0;
            asic_start   <= 1'b0;
            asic_data_in <= '0;
            node_valid   <= 1'b0;
            node_idx     <= '0;
            node_data    <= '0;
            sample_done  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            asic_start  <= 1'b0;
            node_valid  <= 1'b0;
            sample_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (clear) begin
                        idx   <= '0;
                        state <= S_CLEAR;
                        busy  <= 1'b1;
                    end else if (sample_valid) begin
                        sample_q <= sample_data;
                        idx      <= '0;
                        state    <= S_FETCH;
                        busy     <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_FETCH: state <= S_COMPUTE;
                S_COMPUTE: begin
                    asic_data_in <= word;
                    asic_start   <= 1'b1;
                    state        <= S_START;
                end
                S_START: state <= S_WAIT_LOW;
                S_WAIT_LOW: begin
                    if (!asic_ready)
                        state <= S_WAIT_HIGH;
                end
                S_WAIT_HIGH: begin
                    if (asic_ready)
                        state <= S_WRITE;
                end
                S_WRITE: begin
                    node_valid <= 1'b1;
                    node_idx   <= idx;
                    node_data  <= asic_data_out;
                    if (idx == LAST) begin
                        sample_done <= 1'b1;
                        idx         <= '0;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dfr_reservoir_sequencer.sv
// Directed bench: two sequencers (INPUT_SHIFT 1 and 0), each paired with
// an echoing ASIC model that returns its DAC word after a fixed latency.
module tb_dfr_reservoir_sequencer;

    localparam int LAT = 40;
    localparam int TMO = 500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hang = 1'b0;

    always #5 clk = ~clk;

    logic [1:0]       sv, rdy, mwe, clr, ast, ardy, nv, sdn, bsy;
    logic [1:0][15:0] sd, mwd, adi, ado, nd;
    logic [1:0][3:0]  mwa, nidx;

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dfr_reservoir_sequencer #(
            .NUM_NODES(16),
            .INPUT_SHIFT(g == 0 ? 1 : 0),
            .FEEDBACK_SHIFT(1)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .sample_valid(sv[g]),
            .sample_data(sd[g]),
            .sample_ready(rdy[g]),
            .mask_wr_en(mwe[g]),
            .mask_wr_addr(mwa[g]),
            .mask_wr_data(mwd[g]),
            .clear(clr[g]),
            .asic_start(ast[g]),
            .asic_data_in(adi[g]),
            .asic_ready(ardy[g]),
            .asic_data_out(ado[g]),
            .node_valid(nv[g]),
            .node_idx(nidx[g]),
            .node_data(nd[g]),
            .sample_done(sdn[g]),
            .busy(bsy[g])
        );

        logic        m_rdy;
        logic [15:0] m_q;
        logic [15:0] m_lat;
        int          m_cnt;

        always @(posedge clk) begin
            if (rst) begin
                m_rdy <= 1'b1;
                m_q   <= '0;
                m_lat <= '0;
                m_cnt <= 0;
            end else if (ast[g] && !hang) begin
                m_rdy <= 1'b0;
                m_lat <= adi[g];
                m_cnt <= LAT;
            end else if (!m_rdy) begin
                if (m_cnt == 0) begin
                    m_rdy <= 1'b1;
                    m_q   <= m_lat;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end

        assign ardy[g] = m_rdy;
        assign ado[g]  = m_q;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_mask(input int d, input int a, input logic [15:0] v);
        mwe[d] = 1'b1;
        mwa[d] = 4'(a);
        mwd[d] = v;
        tick;
        mwe[d] = 1'b0;
    endtask

    task automatic do_clear(input int d);
        int n;
        n = 0;
        clr[d] = 1'b1;
        tick;
        clr[d] = 1'b0;
        while (bsy[d] && n < TMO) begin
            tick;
            n++;
        end
        if (n >= TMO) begin
            n_cmp++;
            n_bad++;
            $display("FAIL clear_timeout d%0d: busy=%b want 0", d, bsy[d]);
        end
    endtask

    task automatic run_sample(input int d, input logic [15:0] x,
                              input logic [15:0] exp [16], input bit poke);
        int n;
        n = 0;
        while (!rdy[d] && n < TMO) begin
            tick;
            n++;
        end
        sv[d] = 1'b1;
        sd[d] = x;
        tick;
        sv[d] = 1'b0;
        if (poke) begin
            mwe[d] = 1'b1;
            mwa[d] = 4'd5;
            mwd[d] = 16'h0000;
            tick;
            mwe[d] = 1'b0;
        end
        for (int k = 0; k < 16; k++) begin
            n = 0;
            while (!ast[d] && n < TMO) begin
                tick;
                n++;
            end
            n_cmp++;
            if (n >= TMO || adi[d] !== exp[k]) begin
                n_bad++;
                $display("FAIL dac_word d%0d node %0d: got %h want %h (wait %0d)",
                         d, k, adi[d], exp[k], n);
            end
            n = 0;
            while (!nv[d] && n < TMO) begin
                tick;
                n++;
            end
            n_cmp++;
            if (n >= TMO || nidx[d] !== 4'(k)) begin
                n_bad++;
                $display("FAIL node_idx d%0d node %0d: got %0d want %0d",
                         d, k, nidx[d], k);
            end
            n_cmp++;
            if (nd[d] !== exp[k]) begin
                n_bad++;
                $display("FAIL node_data d%0d node %0d: got %h want %h",
                         d, k, nd[d], exp[k]);
            end
            n_cmp++;
            if (sdn[d] !== (k == 15)) begin
                n_bad++;
                $display("FAIL sample_done d%0d node %0d: got %b want %b",
                         d, k, sdn[d], (k == 15));
            end
        end
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_cmp++;
        if ({ast[0], nv[0], sdn[0], bsy[0]} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_pulses: got %b want 0000",
                     {ast[0], nv[0], sdn[0], bsy[0]});
        end
        n_cmp++;
        if (adi[0] !== 16'h0 || nd[0] !== 16'h0 || nidx[0] !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h/%h/%h want 0/0/0",
                     adi[0], nd[0], nidx[0]);
        end
        rst = 1'b0;
        tick;
        n_cmp++;
        if (rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", rdy[0]);
        end
    endtask

    task automatic test_clear_priority;
        int n;
        int starts;
        sv[0] = 1'b1;
        sd[0] = 16'h1234;
        clr[0] = 1'b1;
        #1;
        n_cmp++;
        if (rdy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_ready: got %b want 0", rdy[0]);
        end
        tick;
        sv[0] = 1'b0;
        clr[0] = 1'b0;
        n = 0;
        starts = 0;
        while (bsy[0] && n < TMO) begin
            if (ast[0]) starts++;
            tick;
            n++;
        end
        n_cmp++;
        if (n !== 16) begin
            n_bad++;
            $display("FAIL clear_cycles: got %0d want 16", n);
        end
        for (int k = 0; k < 10; k++) begin
            if (ast[0] || bsy[0]) starts++;
            tick;
        end
        n_cmp++;
        if (starts !== 0) begin
            n_bad++;
            $display("FAIL clear_consumed: got %0d starts want 0", starts);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        n = 0;
        sv[0] = 1'b1;
        sd[0] = 16'h8000;
        tick;
        sv[0] = 1'b0;
        while (!ast[0] && n < TMO) begin
            tick;
            n++;
        end
        repeat (5) tick;
        n_cmp++;
        if (bsy[0] !== 1'b1 || ardy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_busy: got busy %b ready %b want 1 0",
                     bsy[0], ardy[0]);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++;
        if ({bsy[0], ast[0], rdy[0]} !== 3'b001) begin
            n_bad++;
            $display("FAIL mid_reset: got busy/start/ready %b want 001",
                     {bsy[0], ast[0], rdy[0]});
        end
        tick;
    endtask

    task automatic test_basic_and_feedback;
        logic [15:0] exp [16];
        for (int i = 0; i < 16; i++) exp[i] = 16'h2000;
        run_sample(0, 16'h8000, exp, 1'b0);
        for (int i = 0; i < 16; i++) exp[i] = 16'h3000;
        run_sample(0, 16'h8000, exp, 1'b0);
    endtask

    task automatic test_node_mask;
        logic [15:0] exp [16];
        for (int i = 0; i < 16; i++) begin
            wr_mask(0, i, 16'(i << 12));
            exp[i] = (i == 0) ? 16'h0000 : 16'(i * 16'h0800 - 1);
        end
        do_clear(0);
        run_sample(0, 16'hFFFF, exp, 1'b1);
        do_clear(0);
        run_sample(0, 16'hFFFF, exp, 1'b0);
    endtask

    task automatic test_saturation;
        logic [15:0] exp [16];
        for (int i = 0; i < 16; i++) wr_mask(1, i, 16'hFFFF);
        do_clear(1);
        for (int i = 0; i < 16; i++) exp[i] = 16'hFFFE;
        run_sample(1, 16'hFFFF, exp, 1'b0);
        for (int i = 0; i < 16; i++) exp[i] = 16'hFFFF;
        run_sample(1, 16'hFFFF, exp, 1'b0);
    endtask

    task automatic test_hang;
        int starts;
        int nodes;
        starts = 0;
        nodes = 0;
        hang = 1'b1;
        sv[0] = 1'b1;
        sd[0] = 16'h4000;
        tick;
        sv[0] = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (ast[0]) starts++;
            if (nv[0]) nodes++;
            tick;
        end
        n_cmp++;
        if (starts !== 1 || nodes !== 0 || bsy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL hang: got starts %0d nodes %0d busy %b want 1 0 1",
                     starts, nodes, bsy[0]);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        hang = 1'b0;
        n_cmp++;
        if (bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL hang_recover: got busy %b ready %b want 0 1",
                     bsy[0], rdy[0]);
        end
    endtask

    initial begin
        sv = '0;
        sd = '0;
        mwe = '0;
        mwa = '0;
        mwd = '0;
        clr = '0;
        test_reset;
        for (int i = 0; i < 16; i++) wr_mask(0, i, 16'h8000);
        test_clear_priority;
        test_reset_mid;
        test_basic_and_feedback;
        test_node_mask;
        test_saturation;
        test_hang;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
